// File: rtl/sack_cc_engine.sv
// Multi-flow SACK congestion-control engine: per-flow context array, two-stage
// event pipeline (S1 = event + context read, S2 = update/write-back/result) with same-flow bypass.
module sack_cc_engine #(
   parameter int NUM_FLOWS    = 16,
   parameter int FLOW_ID_W    = 4,
   parameter int SEQ_W        = 32,
   parameter int WIN_W        = 10,
   parameter int DUP_THRESH   = 3,
   parameter int INIT_CWND    = 1,
   parameter int MIN_SSTHRESH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 evt_valid,
   output logic                 evt_ready,
   input  logic [FLOW_ID_W-1:0] evt_flow_id,
   input  logic [1:0]           evt_type,
   input  logic [SEQ_W-1:0]     evt_cum_ack,
   input  logic [SEQ_W-1:0]     evt_next_new,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [FLOW_ID_W-1:0] out_flow_id,
   output logic                 out_err,
   output logic                 out_mark_rtx,
   output logic [SEQ_W-1:0]     out_rtx_start,
   output logic [SEQ_W-1:0]     out_rtx_end,
   output logic                 out_reset_tmr,
   output logic [WIN_W-1:0]     out_wnd_size
);
   localparam int IDX_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;
   localparam logic [1:0] EVT_INIT = 2'd0;
   localparam logic [1:0] EVT_CACK = 2'd1;
   localparam logic [1:0] EVT_SACK = 2'd2;
   localparam logic [WIN_W-1:0] WIN_MAX = '1;

   typedef struct packed {
      logic [WIN_W-1:0] cwnd;
      logic [WIN_W-1:0] ssthresh;
      logic [WIN_W-1:0] dup;
      logic [WIN_W-1:0] cntr;
      logic [SEQ_W-1:0] recover;
      logic [SEQ_W-1:0] wnd_start;
      logic             in_recovery;
      logic             in_timeout;
   } ctx_t;

   function automatic ctx_t ctx_init(input logic [SEQ_W-1:0] start);
      ctx_t c;
      c           = '0;
      c.cwnd      = WIN_W'(INIT_CWND);
      c.ssthresh  = '1;
      c.wnd_start = start;
      return c;
   endfunction

   // Serial-number compare so that acks across the 2^SEQ_W wrap still count as new.
   function automatic logic seq_gt(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
      logic [SEQ_W-1:0] d;
      d = a - b;
      return (d != '0) && !d[SEQ_W-1];
   endfunction

   function automatic logic [WIN_W-1:0] sat_add(input logic [WIN_W-1:0] a, input logic [WIN_W-1:0] b);
      logic [WIN_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[WIN_W] ? WIN_MAX : s[WIN_W-1:0];
   endfunction

   function automatic logic [WIN_W-1:0] half_floor(input logic [WIN_W-1:0] w);
      logic [WIN_W-1:0] h;
      h = w >> 1;
      return (h < WIN_W'(MIN_SSTHRESH)) ? WIN_W'(MIN_SSTHRESH) : h;
   endfunction

   ctx_t ctx_q [NUM_FLOWS];
   ctx_t ctx_d [NUM_FLOWS];

   logic                 s1_valid_q, s1_valid_d, s1_err_q, s1_err_d;
   logic [FLOW_ID_W-1:0] s1_flow_q, s1_flow_d;
   logic [1:0]           s1_type_q, s1_type_d;
   logic [SEQ_W-1:0]     s1_cum_q, s1_cum_d, s1_nn_q, s1_nn_d;
   ctx_t                 s1_ctx_q, s1_ctx_d;

   logic                 out_valid_q, out_valid_d, out_err_q, out_err_d;
   logic [FLOW_ID_W-1:0] out_flow_id_q, out_flow_id_d;
   logic                 out_mark_q, out_mark_d, out_tmr_q, out_tmr_d;
   logic [SEQ_W-1:0]     out_start_q, out_start_d, out_end_q, out_end_d;
   logic [WIN_W-1:0]     out_wnd_q, out_wnd_d;

   logic             stall, wr_en, evt_err;
   ctx_t             nc;
   logic             res_mark, res_tmr;
   logic [SEQ_W-1:0] res_start, res_end;
   logic [WIN_W-1:0] res_wnd, inc;

   assign stall     = out_valid_q & ~out_ready;
   assign evt_ready = ~stall;
   assign wr_en     = s1_valid_q & ~s1_err_q & ~stall;
   assign evt_err   = int'(evt_flow_id) >= NUM_FLOWS;

   // S2 update: new context and result fields from the S1 event and context.
   always_comb begin
      nc        = s1_ctx_q;
      res_mark  = 1'b0;
      res_tmr   = 1'b0;
      res_start = '0;
      res_end   = '0;
      inc       = sat_add(s1_ctx_q.cntr, WIN_W'(1));
      case (s1_type_q)
         EVT_INIT: nc = ctx_init(s1_cum_q);
         EVT_CACK: begin
            if (seq_gt(s1_cum_q, s1_ctx_q.wnd_start)) begin
               nc.wnd_start = s1_cum_q;
               nc.dup       = '0;
               res_tmr      = 1'b1;
               if (s1_ctx_q.in_timeout && seq_gt(s1_cum_q, s1_ctx_q.recover)) begin
                  nc.in_timeout = 1'b0;
               end else if (s1_ctx_q.in_recovery && seq_gt(s1_cum_q, s1_ctx_q.recover)) begin
                  nc.in_recovery = 1'b0;
                  nc.cwnd        = s1_ctx_q.ssthresh;
                  nc.cntr        = '0;
               end else if (!s1_ctx_q.in_recovery && !s1_ctx_q.in_timeout) begin
                  if (s1_ctx_q.cwnd < s1_ctx_q.ssthresh) begin
                     nc.cwnd = sat_add(s1_ctx_q.cwnd, WIN_W'(1));
                  end else if (inc >= s1_ctx_q.cwnd) begin
                     nc.cwnd = sat_add(s1_ctx_q.cwnd, WIN_W'(1));
                     nc.cntr = '0;
                  end else begin
                     nc.cntr = inc;
                  end
               end
            end
         end
         EVT_SACK: begin
            res_tmr = 1'b1;
            if (!s1_ctx_q.in_timeout) begin
               nc.dup = sat_add(s1_ctx_q.dup, WIN_W'(1));
               if (!s1_ctx_q.in_recovery && nc.dup == WIN_W'(DUP_THRESH)) begin
                  // cwnd deflates to the new ssthresh; dup inflation supplies the window.
                  nc.in_recovery = 1'b1;
                  nc.ssthresh    = half_floor(s1_ctx_q.cwnd);
                  nc.cwnd        = nc.ssthresh;
                  nc.recover     = s1_nn_q - SEQ_W'(1);
                  res_mark       = 1'b1;
                  res_start      = s1_ctx_q.wnd_start;
                  res_end        = s1_ctx_q.wnd_start + SEQ_W'(1);
               end
            end
         end
         default: begin
            nc.ssthresh    = half_floor(s1_ctx_q.cwnd);
            nc.cwnd        = WIN_W'(1);
            nc.dup         = '0;
            nc.cntr        = '0;
            nc.in_timeout  = 1'b1;
            nc.in_recovery = 1'b0;
            nc.recover     = s1_nn_q - SEQ_W'(1);
            res_mark       = 1'b1;
            res_start      = s1_ctx_q.wnd_start;
            res_end        = s1_nn_q;
         end
      endcase
      res_wnd = sat_add(nc.cwnd, nc.in_recovery ? nc.dup : '0);
   end

   always_comb begin
      ctx_d = ctx_q;
      if (wr_en) ctx_d[s1_flow_q[IDX_W-1:0]] = nc;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_err_d   = s1_err_q;
      s1_flow_d  = s1_flow_q;
      s1_type_d  = s1_type_q;
      s1_cum_d   = s1_cum_q;
      s1_nn_d    = s1_nn_q;
      s1_ctx_d   = s1_ctx_q;
      if (!stall) begin
         s1_valid_d = evt_valid;
         s1_err_d   = evt_err;
         s1_flow_d  = evt_flow_id;
         s1_type_d  = evt_type;
         s1_cum_d   = evt_cum_ack;
         s1_nn_d    = evt_next_new;
         // Bypass: a same-flow write-back this edge is newer than the array entry.
         s1_ctx_d   = (wr_en && s1_flow_q == evt_flow_id) ? nc : ctx_q[evt_flow_id[IDX_W-1:0]];
      end
   end

   always_comb begin
      out_valid_d   = out_valid_q;
      out_err_d     = out_err_q;
      out_flow_id_d = out_flow_id_q;
      out_mark_d    = out_mark_q;
      out_start_d   = out_start_q;
      out_end_d     = out_end_q;
      out_tmr_d     = out_tmr_q;
      out_wnd_d     = out_wnd_q;
      if (!stall) begin
         out_valid_d   = s1_valid_q;
         out_err_d     = s1_valid_q & s1_err_q;
         out_flow_id_d = '0;
         out_mark_d    = 1'b0;
         out_start_d   = '0;
         out_end_d     = '0;
         out_tmr_d     = 1'b0;
         out_wnd_d     = '0;
         if (s1_valid_q && !s1_err_q) begin
            out_flow_id_d = s1_flow_q;
            out_mark_d    = res_mark;
            out_start_d   = res_start;
            out_end_d     = res_end;
            out_tmr_d     = res_tmr;
            out_wnd_d     = res_wnd;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_FLOWS; i++) ctx_q[i] <= ctx_init('0);
         s1_valid_q    <= 1'b0;
         s1_err_q      <= 1'b0;
         s1_flow_q     <= '0;
         s1_type_q     <= '0;
         s1_cum_q      <= '0;
         s1_nn_q       <= '0;
         s1_ctx_q      <= '0;
         out_valid_q   <= 1'b0;
         out_err_q     <= 1'b0;
         out_flow_id_q <= '0;
         out_mark_q    <= 1'b0;
         out_start_q   <= '0;
         out_end_q     <= '0;
         out_tmr_q     <= 1'b0;
         out_wnd_q     <= '0;
      end else begin
         ctx_q         <= ctx_d;
         s1_valid_q    <= s1_valid_d;
         s1_err_q      <= s1_err_d;
         s1_flow_q     <= s1_flow_d;
         s1_type_q     <= s1_type_d;
         s1_cum_q      <= s1_cum_d;
         s1_nn_q       <= s1_nn_d;
         s1_ctx_q      <= s1_ctx_d;
         out_valid_q   <= out_valid_d;
         out_err_q     <= out_err_d;
         out_flow_id_q <= out_flow_id_d;
         out_mark_q    <= out_mark_d;
         out_start_q   <= out_start_d;
         out_end_q     <= out_end_d;
         out_tmr_q     <= out_tmr_d;
         out_wnd_q     <= out_wnd_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_err       = out_err_q;
   assign out_flow_id   = out_flow_id_q;
   assign out_mark_rtx  = out_mark_q;
   assign out_rtx_start = out_start_q;
   assign out_rtx_end   = out_end_q;
   assign out_reset_tmr = out_tmr_q;
   assign out_wnd_size  = out_wnd_q;
endmodule
